// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-back, write-allocate cache with tree pseudo-LRU
// Control FSM, tag/valid/dirty storage and line datapath live in this one block.
module cache_nway #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [31:0]                   mem_address,
  input  logic [(2**S_OFFSET)-1:0]      mem_byte_enable,
  input  logic [8*(2**S_OFFSET)-1:0]    mem_wdata,
  output logic [8*(2**S_OFFSET)-1:0]    mem_rdata,
  output logic                          mem_resp,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [31:0]                   pmem_address,
  output logic [8*(2**S_OFFSET)-1:0]    pmem_wdata,
  input  logic [8*(2**S_OFFSET)-1:0]    pmem_rdata,
  input  logic                          pmem_resp
);

  localparam int S_LINE   = 8 * (2**S_OFFSET);
  localparam int S_MASK   = 2**S_OFFSET;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS = 2**S_INDEX;
  localparam int W_BITS   = $clog2(NUM_WAYS);
  localparam int P_BITS   = NUM_WAYS - 1;

  typedef enum logic [1:0] {IDLE, TAG_CHECK, WRITEBACK, FILL} state_t;

  state_t state_q;

  logic [S_TAG-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [S_LINE-1:0]   data_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
  logic [P_BITS-1:0]   plru_q   [NUM_SETS];

  logic [S_TAG-1:0]    tag_q;
  logic [S_INDEX-1:0]  index_q;
  logic                write_q;
  logic                hit_q;
  logic [W_BITS-1:0]   hit_way_q;
  logic [W_BITS-1:0]   victim_q;

  logic [S_INDEX-1:0]  req_index;
  logic [S_TAG-1:0]    req_tag;
  logic                lk_hit;
  logic [W_BITS-1:0]   lk_way;
  logic [W_BITS-1:0]   inv_way;
  logic [W_BITS-1:0]   vic_way;
  logic [S_LINE-1:0]   old_line;
  logic [S_LINE-1:0]   merged_line;
  logic [31:0]         fill_addr;
  logic [31:0]         wb_addr;
  logic                unused_offset;

  // Walk from the root; a 0 bit sends the victim search to the lower half.
  function automatic logic [W_BITS-1:0] plru_victim(input logic [P_BITS-1:0] bits);
    logic [W_BITS-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < W_BITS; l++) begin
      way  = W_BITS'({way, bits[node]});
      node = 2 * node + (bits[node] ? 2 : 1);
    end
    return way;
  endfunction

  function automatic logic [P_BITS-1:0] plru_touch(input logic [P_BITS-1:0] bits,
                                                   input logic [W_BITS-1:0] way);
    logic [P_BITS-1:0] nb;
    int node;
    nb = bits;
    for (int l = 0; l < W_BITS; l++) begin
      node     = (1 << l) - 1 + int'(way >> (W_BITS - l));
      nb[node] = ~way[W_BITS-1-l];
    end
    return nb;
  endfunction

  assign req_index     = mem_address[S_OFFSET +: S_INDEX];
  assign req_tag       = mem_address[31 -: S_TAG];
  assign unused_offset = ^mem_address[S_OFFSET-1:0];
  assign fill_addr     = {tag_q, index_q, {S_OFFSET{1'b0}}};
  assign wb_addr       = {tag_mem[index_q][vic_way], index_q, {S_OFFSET{1'b0}}};

  // Lookup runs on the live request address so the hit response can be registered.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_index][w] && (tag_mem[req_index][w] == req_tag)) begin
        lk_hit = 1'b1;
        lk_way = W_BITS'(w);
      end
    end
  end

  always_comb begin
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[index_q][w]) inv_way = W_BITS'(w);
    end
    vic_way = (&valid_q[index_q]) ? plru_victim(plru_q[index_q]) : inv_way;
  end

  always_comb begin
    old_line    = data_mem[index_q][hit_way_q];
    merged_line = old_line;
    for (int b = 0; b < S_MASK; b++) begin
      if (mem_byte_enable[b]) merged_line[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (state_q == FILL && pmem_resp) begin
      data_mem[index_q][victim_q] <= pmem_rdata;
      tag_mem[index_q][victim_q]  <= tag_q;
    end else if (state_q == TAG_CHECK && hit_q && write_q) begin
      data_mem[index_q][hit_way_q] <= merged_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      index_q      <= '0;
      write_q      <= 1'b0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      victim_q     <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            tag_q     <= req_tag;
            index_q   <= req_index;
            write_q   <= mem_write;
            hit_q     <= lk_hit;
            hit_way_q <= lk_way;
            mem_resp  <= lk_hit;
            if (lk_hit) mem_rdata <= data_mem[req_index][lk_way];
            state_q   <= TAG_CHECK;
          end
        end
        TAG_CHECK: begin
          if (hit_q) begin
            mem_resp        <= 1'b0;
            plru_q[index_q] <= plru_touch(plru_q[index_q], hit_way_q);
            if (write_q) dirty_q[index_q][hit_way_q] <= 1'b1;
            state_q         <= IDLE;
          end else begin
            victim_q <= vic_way;
            if (dirty_q[index_q][vic_way]) begin
              pmem_write   <= 1'b1;
              pmem_address <= wb_addr;
              pmem_wdata   <= data_mem[index_q][vic_way];
              state_q      <= WRITEBACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= fill_addr;
              state_q      <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_q[index_q][victim_q] <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= fill_addr;
            state_q      <= FILL;
          end
        end
        FILL: begin
          // The refilled way is reported as a hit; the next TAG_CHECK finishes the request.
          if (pmem_resp) begin
            pmem_read                  <= 1'b0;
            valid_q[index_q][victim_q] <= 1'b1;
            dirty_q[index_q][victim_q] <= 1'b0;
            hit_q                      <= 1'b1;
            hit_way_q                  <= victim_q;
            mem_resp                   <= 1'b1;
            mem_rdata                  <= pmem_rdata;
            state_q                    <= TAG_CHECK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// tb/tb_cache_nway.sv - directed self-checking bench for cache_nway (4-way default and 2-way build)
module tb_cache_nway;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  mem_address;
  logic [31:0]  mem_byte_enable;
  logic [255:0] mem_wdata;

  logic mem_read0, mem_write0, mem_resp0, pmem_read0, pmem_write0, pmem_resp0;
  logic [255:0] mem_rdata0, pmem_wdata0, pmem_rdata0;
  logic [31:0]  pmem_address0;
  logic mem_read1, mem_write1, mem_resp1, pmem_read1, pmem_write1, pmem_resp1;
  logic [255:0] mem_rdata1, pmem_wdata1, pmem_rdata1;
  logic [31:0]  pmem_address1;

  int checks = 0;
  int failures = 0;
  int n_rd0 = 0, n_wr0 = 0, cnt0 = 0, n_rd1 = 0, n_wr1 = 0, cnt1 = 0;
  logic both0 = 1'b0, both1 = 1'b0;
  logic [31:0]  rd_addr0, wr_addr0, rd_addr1;
  logic [255:0] wr_data0;

  always #5 clk = ~clk;

  cache_nway u0 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read0), .mem_write(mem_write0),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata0), .mem_resp(mem_resp0), .pmem_read(pmem_read0),
    .pmem_write(pmem_write0), .pmem_address(pmem_address0), .pmem_wdata(pmem_wdata0),
    .pmem_rdata(pmem_rdata0), .pmem_resp(pmem_resp0)
  );

  cache_nway #(.S_OFFSET(5), .S_INDEX(4), .NUM_WAYS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata1), .mem_resp(mem_resp1), .pmem_read(pmem_read1),
    .pmem_write(pmem_write1), .pmem_address(pmem_address1), .pmem_wdata(pmem_wdata1),
    .pmem_rdata(pmem_rdata1), .pmem_resp(pmem_resp1)
  );

  function automatic logic [255:0] fd(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_A5A5}};
  endfunction

  // Memory models: respond in the third cycle a request is held, then drop resp.
  initial begin
    pmem_resp0 = 1'b0;
    pmem_rdata0 = '0;
    forever begin
      @(negedge clk);
      if (pmem_read0 && pmem_write0) both0 = 1'b1;
      if (pmem_resp0) begin
        pmem_resp0 = 1'b0;
        cnt0 = (pmem_read0 || pmem_write0) ? 1 : 0;
      end else if (pmem_read0 || pmem_write0) begin
        if (cnt0 == 2) begin
          pmem_resp0  = 1'b1;
          pmem_rdata0 = fd(pmem_address0);
          cnt0 = 0;
          if (pmem_write0) begin
            n_wr0++; wr_addr0 = pmem_address0; wr_data0 = pmem_wdata0;
          end else begin
            n_rd0++; rd_addr0 = pmem_address0;
          end
        end else cnt0++;
      end else cnt0 = 0;
    end
  end

  initial begin
    pmem_resp1 = 1'b0;
    pmem_rdata1 = '0;
    forever begin
      @(negedge clk);
      if (pmem_read1 && pmem_write1) both1 = 1'b1;
      if (pmem_resp1) begin
        pmem_resp1 = 1'b0;
        cnt1 = (pmem_read1 || pmem_write1) ? 1 : 0;
      end else if (pmem_read1 || pmem_write1) begin
        if (cnt1 == 2) begin
          pmem_resp1  = 1'b1;
          pmem_rdata1 = fd(pmem_address1);
          cnt1 = 0;
          if (pmem_write1) n_wr1++;
          else begin
            n_rd1++; rd_addr1 = pmem_address1;
          end
          if (^pmem_wdata1 === 1'bx) both1 = 1'b1;
        end else cnt1++;
      end else cnt1 = 0;
    end
  end

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // total = cycles from the request cycle through the mem_resp cycle; -1 on timeout.
  task automatic access(input int u, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] be, input logic [255:0] wd,
                        output logic [255:0] rdata, output int total);
    @(negedge clk);
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = wd;
    if (u == 0) begin mem_read0 = rd; mem_write0 = wr; end
    else begin mem_read1 = rd; mem_write1 = wr; end
    total = -1;
    rdata = '0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if ((u == 0 && mem_resp0) || (u == 1 && mem_resp1)) begin
        total = i + 1;
        rdata = (u == 0) ? mem_rdata0 : mem_rdata1;
        break;
      end
    end
    mem_read0 = 1'b0; mem_write0 = 1'b0; mem_read1 = 1'b0; mem_write1 = 1'b0;
  endtask

  initial begin
    logic [255:0] rd, wd, exp, exp2;
    logic [31:0] addrs [3];
    int tot, seen;
    rst_n = 1'b0;
    mem_read0 = 1'b0; mem_write0 = 1'b0; mem_read1 = 1'b0; mem_write1 = 1'b0;
    mem_address = '0; mem_byte_enable = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk_int("rst_mem_resp", int'(mem_resp0), 0);
    chk_int("rst_pmem_read", int'(pmem_read0), 0);
    chk_int("rst_pmem_write", int'(pmem_write0), 0);
    chk_int("rst_pmem_address", int'(pmem_address0), 0);
    chk_line("rst_mem_rdata", mem_rdata0, '0);
    chk_line("rst_pmem_wdata", pmem_wdata0, '0);
    rst_n = 1'b1;

    access(0, 1'b1, 1'b0, 32'h40, '0, '0, rd, tot);
    chk_int("cold_latency", tot, 6);
    chk_line("cold_data", rd, fd(32'h40));
    chk_int("cold_pmem_reads", n_rd0, 1);
    chk_int("cold_pmem_addr", int'(rd_addr0), 32'h40);
    access(0, 1'b1, 1'b0, 32'h40, '0, '0, rd, tot);
    chk_int("hit_latency", tot, 2);
    chk_line("hit_data", rd, fd(32'h40));
    chk_int("hit_no_pmem", n_rd0, 1);

    wd = '0; wd[31:0] = 32'hDEAD_BEEF;
    access(0, 1'b0, 1'b1, 32'h40, 32'h0000_000F, wd, rd, tot);
    chk_int("wrhit_latency", tot, 2);
    exp = fd(32'h40); exp[31:0] = 32'hDEAD_BEEF;
    access(0, 1'b1, 1'b0, 32'h40, '0, '0, rd, tot);
    chk_line("wrhit_readback", rd, exp);

    for (int t = 1; t <= 4; t++) begin
      access(0, 1'b1, 1'b0, 32'(t << 8), '0, '0, rd, tot);
      chk_line("set0_fill", rd, fd(32'(t << 8)));
    end
    for (int t = 1; t <= 4; t++) begin
      access(0, 1'b1, 1'b0, 32'(t << 8), '0, '0, rd, tot);
      chk_int("set0_touch_hit", tot, 2);
    end
    chk_int("set0_reads", n_rd0, 5);
    access(0, 1'b1, 1'b0, 32'h500, '0, '0, rd, tot);
    chk_int("plru_miss_latency", tot, 6);
    chk_line("plru_miss_data", rd, fd(32'h500));
    access(0, 1'b1, 1'b0, 32'h100, '0, '0, rd, tot);
    chk_int("way0_evicted", tot, 6);
    chk_int("clean_no_writeback", n_wr0, 0);

    wd = '0; wd[63:32] = 32'h1234_5678;
    access(0, 1'b0, 1'b1, 32'h200, 32'h0000_00F0, wd, rd, tot);
    chk_int("dirty_write_hit", tot, 2);
    addrs[0] = 32'h400; addrs[1] = 32'h500; addrs[2] = 32'h100;
    for (int k = 0; k < 3; k++) begin
      access(0, 1'b1, 1'b0, addrs[k], '0, '0, rd, tot);
      chk_int("reorder_hit", tot, 2);
    end
    access(0, 1'b1, 1'b0, 32'h600, '0, '0, rd, tot);
    exp2 = fd(32'h200); exp2[63:32] = 32'h1234_5678;
    chk_int("dirty_miss_latency", tot, 9);
    chk_int("wb_count", n_wr0, 1);
    chk_int("wb_address", int'(wr_addr0), 32'h200);
    chk_line("wb_data", wr_data0, exp2);
    chk_int("fill_after_wb_addr", int'(rd_addr0), 32'h600);
    chk_line("fill_after_wb_data", rd, fd(32'h600));
    chk_int("never_both_u0", int'(both0), 0);

    @(negedge clk);
    mem_address = 32'h700; mem_read0 = 1'b1;
    for (int g = 0; g < 20; g++) begin
      @(posedge clk); #1;
      if (pmem_read0) break;
    end
    chk_int("fill_started", int'(pmem_read0), 1);
    rst_n = 1'b0;
    #1;
    chk_int("async_pmem_read_drop", int'(pmem_read0), 0);
    @(negedge clk); mem_read0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_resp0) seen++;
    end
    chk_int("no_resp_after_reset", seen, 0);
    tot = n_rd0;
    access(0, 1'b1, 1'b0, 32'h40, '0, '0, rd, tot);
    chk_int("valid_cleared_miss", tot, 6);
    chk_line("valid_cleared_data", rd, fd(32'h40));

    wd = '0; wd[7:0] = 8'h77;
    access(0, 1'b1, 1'b1, 32'h40, 32'h0000_0001, wd, rd, tot);
    chk_int("rdwr_latency", tot, 2);
    exp = fd(32'h40); exp[7:0] = 8'h77;
    access(0, 1'b1, 1'b0, 32'h40, '0, '0, rd, tot);
    chk_line("rdwr_is_write", rd, exp);

    access(1, 1'b1, 1'b0, 32'h000, '0, '0, rd, tot);
    chk_int("w2_a_miss", tot, 6);
    access(1, 1'b1, 1'b0, 32'h200, '0, '0, rd, tot);
    chk_int("w2_b_miss", tot, 6);
    access(1, 1'b1, 1'b0, 32'h000, '0, '0, rd, tot);
    chk_int("w2_a_hit", tot, 2);
    access(1, 1'b1, 1'b0, 32'h400, '0, '0, rd, tot);
    chk_int("w2_c_miss", tot, 6);
    chk_line("w2_c_data", rd, fd(32'h400));
    chk_int("w2_c_fill_addr", int'(rd_addr1), 32'h400);
    access(1, 1'b1, 1'b0, 32'h000, '0, '0, rd, tot);
    chk_int("w2_a_kept", tot, 2);
    access(1, 1'b1, 1'b0, 32'h200, '0, '0, rd, tot);
    chk_int("w2_b_evicted", tot, 6);
    chk_int("w2_reads", n_rd1, 4);
    chk_int("w2_no_writeback", n_wr1, 0);
    chk_int("never_both_u1", int'(both1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
